byte_serial_addsub: RTL
=======================

# byte_serial_addsub

Multi-cycle signed/unsigned adder-subtractor that computes WIDTH-bit A±B one byte per clock. It sits directly around the existing 8-bit ripple-carry slice `rca8`: it feeds one operand byte pair per cycle, consumes the slice's sum byte and carry-out, and registers the carry between bytes. It is used where a full-width combinational carry chain is too slow or too large. Results are presented to downstream logic through a start/done handshake.

## Interface
- WIDTH, 32, operand and result width; must be a multiple of 8 and at least 8.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset; everything in this block uses this one clock.
- start  in  1  request; sampled on a rising edge only while busy=0.
- a  in  WIDTH  operand A; captured on accept.
- b  in  WIDTH  operand B; captured on accept.
- mode  in  1  0 = A+B, 1 = A−B (two's complement); captured on accept.
- busy  out  1  high while an operation is in progress.
- done  out  1  one-cycle pulse when s, cout and ovf become valid.
- s  out  WIDTH  result; held until the next accept.
- cout  out  1  carry-out of the MSB byte; for subtraction, 1 means no borrow.
- ovf  out  1  signed overflow (see Configuration).

## Operation
- State machine has two states, IDLE (busy=0) and RUN (busy=1). The byte index idx is ceil(log2(WIDTH/8)) bits wide, minimum 1 bit.
- **Accept** (IDLE and start=1 at an edge):
  - Latch a, b and mode.
  - Set carry register to mode, idx to 0, s to 0, cout and ovf to 0.
  - Move to RUN.
- **RUN, each edge:**
  - Slice inputs are A byte[idx] and B byte[idx], with B XORed with {8{mode}}. Carry-in is the carry register.
  - Write the sum into s byte[idx]. Load the carry register with the slice carry-out. Increment idx.
- **Final byte** (idx = WIDTH/8−1) on that same edge:
  - Load cout with the slice carry-out and compute ovf.
  - Assert done for one cycle and return to IDLE.
- Arithmetic is modulo 2^WIDTH. s is bit-exact with (A + (B^{WIDTH{mode}}) + mode) truncated to WIDTH bits.
- start while busy=1 is ignored. The captured operands do not change during RUN.
- a, b and mode may change freely after the accept edge.

## Timing
- Reset values: busy=0, done=0, s=0, cout=0, ovf=0, state=IDLE, carry=0, idx=0.
- Latency: done is high during the cycle after the (WIDTH/8)-th edge following the accept edge. For WIDTH=32, accept at edge 0 puts done high between edges 4 and 5.
- busy rises on the accept edge and falls on the same edge done rises.
- Throughput: start held high in the done cycle is accepted at the next edge, because busy is already 0. That edge clears done and zeroes s. Back-to-back issue gives one result per WIDTH/8+1 cycles.
- During RUN, s shows partially written bytes. Consumers use s only when done=1 or while IDLE after done.
- rst_n asserted mid-operation: all outputs go to reset values immediately (asynchronously). The operation is lost and no done pulse is produced.
- rst_n deassertion is synchronised externally; start on the first edge after release is accepted.

## Configuration
- Macro OVERFLOW_FLAG_EN.
- **Defined:** on the final-byte edge, ovf = (A[W−1] == B'[W−1]) && (sum[W−1] != A[W−1]), where B' = B^{WIDTH{mode}} and sum[W−1] is the result MSB. ovf is held with s.
- **Undefined:** ovf is tied to constant 0 and no overflow logic is synthesised. All other behaviour is identical.

## Test plan
- WIDTH=32, a=0x000000FF, b=0x00000001, mode=0 → s=0x00000100, cout=0, ovf=0. done is high exactly in the cycle after edge 4 after accept, and busy is high for 4 cycles.
- a=0xFFFFFFFF, b=0x00000001, mode=0 → s=0x00000000, cout=1, ovf=0 (carry ripples through all four bytes).
- a=0x7FFFFFFF, b=0x00000001, mode=0 → s=0x80000000, cout=0. With OVERFLOW_FLAG_EN, ovf=1; without it, ovf=0.
- a=5, b=7, mode=1 → s=0xFFFFFFFE, cout=0. Then a=7, b=5, mode=1 issued back-to-back in the done cycle → s=0x00000002, cout=1, done 5 cycles after the first done.
- Pulse start with a=1, b=1, mode=0, then drive start=1 with a=0x10, b=0x20 while busy → the second request is ignored, s=0x00000002, and exactly one done pulse occurs.
- Assert rst_n=0 two cycles into RUN → busy, done, s, cout and ovf become 0 immediately. After release, a fresh a=3, b=4, mode=0 gives s=7.

Source files
------------

// File: rtl/byte_serial_addsub.sv
// byte_serial_addsub: WIDTH-bit A+/-B computed one byte per clock around rca8.
// Define OVERFLOW_FLAG_EN to build the signed overflow flag; otherwise ovf is tied to 0.
module rca8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] s,
  output logic       cout
);
  logic c;
  always_comb begin
    c = cin;
    s = '0;
    for (int i = 0; i < 8; i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      c = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end
endmodule

module byte_serial_addsub #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mode,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);
  localparam int N = WIDTH / 8;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  typedef enum logic {IDLE, RUN} state_t;
  state_t state;
  logic [N-1:0][7:0] ra, rb, s_q;
  logic rmode, carry, slice_cout, last;
  logic [IW-1:0] idx;
  logic [7:0] a_byte, b_byte, sum;
  assign a_byte = ra[idx];
  assign b_byte = rb[idx] ^ {8{rmode}};
  assign last = idx == IW'(N - 1);
  assign busy = state == RUN;
  assign s = s_q;
  rca8 u_rca8 (.a(a_byte), .b(b_byte), .cin(carry), .s(sum), .cout(slice_cout));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ra    <= '0;
      rb    <= '0;
      rmode <= 1'b0;
      carry <= 1'b0;
      idx   <= '0;
      s_q   <= '0;
      cout  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          ra    <= a;
          rb    <= b;
          rmode <= mode;
          carry <= mode;
          idx   <= '0;
          s_q   <= '0;
          cout  <= 1'b0;
          state <= RUN;
        end
      end else begin
        s_q[idx] <= sum;
        carry    <= slice_cout;
        idx      <= idx + 1'b1;
        if (last) begin
          cout  <= slice_cout;
          done  <= 1'b1;
          state <= IDLE;
        end
      end
    end
  end
`ifdef OVERFLOW_FLAG_EN
  logic ovf_q;
  assign ovf = ovf_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ovf_q <= 1'b0;
    else if (state == IDLE && start)
      ovf_q <= 1'b0;
    else if (state == RUN && last)
      ovf_q <= (a_byte[7] == b_byte[7]) && (sum[7] != a_byte[7]);
  end
`else
  assign ovf = 1'b0;
`endif
endmodule
